blft_win_sched: RTL

Window scheduler for the bilateral-filter datapath. It rasters over the interior output pixels of an IMG_H x IMG_W image and fetches each (2R+1)x(2R+1) neighbourhood through a request/grant pixel-read port. It reuses columns across adjacent outputs, triggers the datapath calculation, and publishes the output pixel address. It sits between pixel memory / testbench and the filter arithmetic core.

---
 rtl/blft_win_sched_if.sv | 30 +++
 rtl/blft_win_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/blft_win_sched_if.sv
// Handshake bundle between the window scheduler, pixel memory and the filter core.
interface blft_win_sched_if #(
  parameter int unsigned AW = 8
);
  logic            start;
  logic            busy;
  logic            done;
  logic            rd_req;
  logic [2*AW-1:0] rd_addr;
  logic            rd_gnt;
  logic [4:0]      win_row;
  logic [4:0]      win_col;
  logic            win_shift;
  logic            calc_start;
  logic            calc_done;
  logic            out_valid;
  logic [2*AW-1:0] out_addr;

  modport master (
    input  start, rd_gnt, calc_done,
    output busy, done, rd_req, rd_addr, win_row, win_col,
           win_shift, calc_start, out_valid, out_addr
  );

  modport slave (
    output start, rd_gnt, calc_done,
    input  busy, done, rd_req, rd_addr, win_row, win_col,
           win_shift, calc_start, out_valid, out_addr
  );
endinterface

// File: rtl/blft_win_sched.sv
// Bilateral-filter window scheduler: rasters interior output pixels, fetches each
// (2R+1)^2 window (reusing columns along a row), starts the core and publishes results.
module blft_win_sched #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned AW     = 8,
  parameter int unsigned RADIUS = 5
) (
  input  logic              clk,
  input  logic              rst,
  blft_win_sched_if.master  bus
);

  localparam logic [4:0]    KM1    = 5'(2 * RADIUS);
  localparam logic [AW-1:0] R_A    = AW'(RADIUS);
  localparam logic [AW-1:0] PX_MAX = AW'(IMG_W - 1 - RADIUS);
  localparam logic [AW-1:0] PY_MAX = AW'(IMG_H - 1 - RADIUS);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SHIFT, S_SLIDE, S_CALC_ISSUE, S_CALC_WAIT, S_EMIT, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   py_q, py_d, px_q, px_d;
  logic [4:0]      fr_q, fr_d, fc_q, fc_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            rd_req_q, rd_req_d;
  logic [2*AW-1:0] rd_addr_q, rd_addr_d;
  logic [4:0]      win_row_q, win_row_d, win_col_q, win_col_d;
  logic            win_shift_q, win_shift_d, calc_start_q, calc_start_d;
  logic            out_valid_q, out_valid_d;
  logic [2*AW-1:0] out_addr_q, out_addr_d;
  logic [AW-1:0]   fetch_row, fetch_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      py_q         <= R_A;
      px_q         <= R_A;
      fr_q         <= '0;
      fc_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_shift_q  <= 1'b0;
      calc_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      py_q         <= py_d;
      px_q         <= px_d;
      fr_q         <= fr_d;
      fc_q         <= fc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      win_shift_q  <= win_shift_d;
      calc_start_q <= calc_start_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
    end
  end

  // Next state and counters; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    py_d    = py_q;
    px_d    = px_q;
    fr_d    = fr_q;
    fc_d    = fc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FILL;
          py_d    = R_A;
          px_d    = R_A;
          fr_d    = '0;
          fc_d    = '0;
        end
      end
      S_FILL: begin
        if (bus.rd_gnt) begin
          if (fr_q == KM1) begin
            fr_d = '0;
            if (fc_q == KM1) begin
              fc_d    = '0;
              state_d = S_CALC_ISSUE;
            end else begin
              fc_d = fc_q + 5'd1;
            end
          end else begin
            fr_d = fr_q + 5'd1;
          end
        end
      end
      S_SHIFT: begin
        fr_d    = '0;
        state_d = S_SLIDE;
      end
      S_SLIDE: begin
        if (bus.rd_gnt) begin
          if (fr_q == KM1) begin
            fr_d    = '0;
            state_d = S_CALC_ISSUE;
          end else begin
            fr_d = fr_q + 5'd1;
          end
        end
      end
      S_CALC_ISSUE: state_d = S_CALC_WAIT;
      S_CALC_WAIT: begin
        if (bus.calc_done) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (px_q < PX_MAX) begin
          px_d    = px_q + AW'(1);
          state_d = S_SHIFT;
        end else if (py_q < PY_MAX) begin
          px_d    = R_A;
          py_d    = py_q + AW'(1);
          fr_d    = '0;
          fc_d    = '0;
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Window-relative fetch address; never wraps for interior outputs.
    fetch_row = py_d - R_A + AW'(fr_d);
    fetch_col = (state_d == S_SLIDE) ? (px_d + R_A) : (px_d - R_A + AW'(fc_d));

    rd_req_d     = (state_d == S_FILL) || (state_d == S_SLIDE);
    rd_addr_d    = rd_req_d ? {fetch_row, fetch_col} : '0;
    win_row_d    = rd_req_d ? fr_d : 5'd0;
    win_col_d    = (state_d == S_FILL) ? fc_d : ((state_d == S_SLIDE) ? KM1 : 5'd0);
    win_shift_d  = (state_d == S_SHIFT);
    calc_start_d = (state_d == S_CALC_ISSUE);
    out_valid_d  = (state_d == S_EMIT);
    out_addr_d   = (state_d == S_EMIT) ? {py_d, px_d} : out_addr_q;
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_shift  = win_shift_q;
  assign bus.calc_start = calc_start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = out_addr_q;

endmodule
